ula_seq_32: RTL and testbench

- Multi-cycle sequencer that performs 32-bit 74181-style operations by time-multiplexing one ula_8_bits instance over four byte slices, LSB first.
- The ALU carry is chained through a register between slices.
- Sits between a requester (start/done handshake) and the shared 8-bit ALU datapath. It trades 4 cycles of latency for one-quarter of the ALU area.

---
 rtl/ula_seq_pkg.sv | 23 ++
 rtl/ula_seq_32_ula_8_bits.sv | 28 ++
 rtl/ula_seq_32.sv | 133 +++++++++++++
 tb/tb_ula_seq_32.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/ula_seq_pkg.sv
// Shared types and constants for the byte-serial 74181-style sequencer.
package ula_seq_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Byte-index width; a single-slice build still needs one bit.
    function automatic int idx_w(input int n_bytes);
        return (n_bytes > 1) ? $clog2(n_bytes) : 1;
    endfunction

    // Common 74181 selects. XOR and SUB share an encoding; m picks the meaning.
    localparam logic [3:0] S_ADD = 4'b1001;  // m=0: A plus B
    localparam logic [3:0] S_SUB = 4'b0110;  // m=0: A minus B minus 1 (with c_in=1)
    localparam logic [3:0] S_XOR = 4'b0110;  // m=1: A xor B
    localparam logic [3:0] S_AND = 4'b1011;  // m=1: A and B

endpackage

// File: rtl/ula_seq_32_ula_8_bits.sv
// 8-bit 74181-style ALU slice: active-high data, active-low carry in/out.
module ula_8_bits (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       c_in,
    output logic [7:0] f,
    output logic       c_out,
    output logic       a_eq_b
);

    logic [7:0] op1;
    logic [7:0] op2;
    logic [8:0] sum;

    // The select lines pick two operand terms; arithmetic adds them, logic
    // mode takes their inverted XOR. a_eq_b is the open-collector "F all ones".
    always_comb begin
        op1    = a | (b & {8{s[0]}}) | (~b & {8{s[1]}});
        op2    = (a & ~b & {8{s[2]}}) | (a & b & {8{s[3]}});
        sum    = {1'b0, op1} + {1'b0, op2} + {8'b0, ~c_in};
        f      = m ? ~(op1 ^ op2) : sum[7:0];
        c_out  = ~sum[8];
        a_eq_b = &f;
    end

endmodule

// File: rtl/ula_seq_32.sv
// 32-bit 74181-style operation built by running one 8-bit ALU over the
// operand bytes LSB first, with the carry held in a register between slices.
//
// state | meaning
// IDLE  | waiting for start; result registers hold the last answer
// RUN   | one byte slice per cycle, idx selects the slice
// DONE  | one-cycle done pulse, result complete
module ula_seq_32
    import ula_seq_pkg::*;
#(
    parameter int N_BYTES = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BYTE_W*N_BYTES-1:0] a,
    input  logic [BYTE_W*N_BYTES-1:0] b,
    input  logic [3:0]                s,
    input  logic                      m,
    input  logic                      c_in,
    output logic                      busy,
    output logic                      done,
    output logic [BYTE_W*N_BYTES-1:0] f,
    output logic                      c_out,
    output logic                      a_eq_b
);

    localparam int W  = BYTE_W * N_BYTES;
    localparam int IW = idx_w(N_BYTES);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_BYTES - 1);

    state_t          state;
    state_t          state_nx;
    logic [W-1:0]    a_r;
    logic [W-1:0]    b_r;
    logic [3:0]      s_r;
    logic            m_r;
    logic            carry_r;
    logic            eq_r;
    logic [IW-1:0]   idx;
    logic [W-1:0]    f_r;
    logic            c_out_r;
    logic            a_eq_b_r;

    logic [BYTE_W-1:0] alu_a;
    logic [BYTE_W-1:0] alu_b;
    logic [BYTE_W-1:0] alu_f;
    logic              alu_c_out;
    logic              alu_a_eq_b;
    logic              last_slice;

    assign alu_a      = a_r[idx*BYTE_W +: BYTE_W];
    assign alu_b      = b_r[idx*BYTE_W +: BYTE_W];
    assign last_slice = (idx == IDX_LAST);

    ula_8_bits u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .s      (s_r),
        .m      (m_r),
        .c_in   (carry_r),
        .f      (alu_f),
        .c_out  (alu_c_out),
        .a_eq_b (alu_a_eq_b)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic; start is only looked at in IDLE, so it never queues.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_slice) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operand capture, slice write-back and carry/equality chaining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r      <= '0;
            b_r      <= '0;
            s_r      <= '0;
            m_r      <= 1'b0;
            carry_r  <= 1'b1;
            eq_r     <= 1'b0;
            idx      <= '0;
            f_r      <= '0;
            c_out_r  <= 1'b0;
            a_eq_b_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r     <= a;
                        b_r     <= b;
                        s_r     <= s;
                        m_r     <= m;
                        carry_r <= c_in;
                        eq_r    <= 1'b1;
                        idx     <= '0;
                    end
                end
                RUN: begin
                    f_r[idx*BYTE_W +: BYTE_W] <= alu_f;
                    carry_r <= alu_c_out;
                    eq_r    <= eq_r & alu_a_eq_b;
                    if (last_slice) begin
                        idx      <= '0;
                        c_out_r  <= alu_c_out;
                        a_eq_b_r <= eq_r & alu_a_eq_b;
                    end else begin
                        idx <= idx + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy   = (state != IDLE);
    assign done   = (state == DONE);
    assign f      = f_r;
    assign c_out  = c_out_r;
    assign a_eq_b = a_eq_b_r;

endmodule

// File: tb/tb_ula_seq_32.sv
// Scoreboard bench for ula_seq_32: stimulus pushes hand-computed results,
// a negedge monitor pops and compares on every done pulse and checks the
// cleared outputs while reset is held.
module tb_ula_seq_32;
    import ula_seq_pkg::*;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;
    logic [3:0]  s     = '0;
    logic        m     = 1'b0;
    logic        c_in  = 1'b1;
    logic        busy;
    logic        done;
    logic [31:0] f;
    logic        c_out;
    logic        a_eq_b;

    ula_seq_32 #(.N_BYTES(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .s      (s),
        .m      (m),
        .c_in   (c_in),
        .busy   (busy),
        .done   (done),
        .f      (f),
        .c_out  (c_out),
        .a_eq_b (a_eq_b)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] f;
        logic        c;
        logic        eq;
        int          cyc_done;
        string       name;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int errors   = 0;
    int tmo_req  = 0;
    int tmo_seen = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp_v);
        end
    endtask

    // Monitor: reset-state checks, scoreboard compare on done, timeout reports.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("rst_busy",   32'(busy),   32'd0);
            check("rst_done",   32'(done),   32'd0);
            check("rst_f",      f,           32'd0);
            check("rst_c_out",  32'(c_out),  32'd0);
            check("rst_a_eq_b", 32'(a_eq_b), 32'd0);
        end else if (done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done got done=1 at cycle %0d want no done", cyc);
            end else begin
                e = sb.pop_front();
                check({e.name, "_f"},      f,           e.f);
                check({e.name, "_c_out"},  32'(c_out),  32'(e.c));
                check({e.name, "_a_eq_b"}, 32'(a_eq_b), 32'(e.eq));
                check({e.name, "_busy"},   32'(busy),   32'd1);
                check({e.name, "_cycle"},  32'(cyc),    32'(e.cyc_done));
            end
        end
        if (tmo_seen != tmo_req) begin
            checks++;
            errors++;
            $display("FAIL timeout got no done within bound want done (%0d pending)", tmo_req - tmo_seen);
            tmo_seen = tmo_req;
        end
    end

    task automatic wait_idle();
        int k = 0;
        while (sb.size() != 0 && k < 40) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            tmo_req++;
            sb.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run_op(input string nm, input logic [31:0] av, input logic [31:0] bv,
                          input logic [3:0] sv, input logic mv, input logic cv,
                          input logic [31:0] ef, input logic ec, input logic eeq);
        @(negedge clk);
        a = av; b = bv; s = sv; m = mv; c_in = cv; start = 1'b1;
        sb.push_back('{f: ef, c: ec, eq: eeq, cyc_done: cyc + 5, name: nm});
        @(negedge clk);
        start = 1'b0;
        a = ~av; b = bv ^ 32'h5A5A_5A5A; s = ~sv; m = ~mv; c_in = ~cv;
        wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got no finish want finish by 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] sum33;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        run_op("xor",   32'hF0F0_1234, 32'h0FF0_FFFF, S_XOR, 1'b1, 1'b1, 32'hFF00_EDCB, 1'b0, 1'b0);
        run_op("add24", 32'h00FF_FFFF, 32'h0000_0001, S_ADD, 1'b0, 1'b1, 32'h0100_0000, 1'b1, 1'b0);

        // Abort mid-operation: reset lands after the third slice write.
        @(negedge clk);
        a = 32'hF0F0_1234; b = 32'h0FF0_FFFF; s = S_XOR; m = 1'b1; c_in = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (8) @(negedge clk);

        run_op("addovf", 32'hFFFF_FFFF, 32'h0000_0001, S_ADD, 1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0);
        run_op("subeq",  32'h1234_5678, 32'h1234_5678, S_SUB, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b1);
        run_op("subne",  32'h1234_5678, 32'h1234_5679, S_SUB, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b0);
        run_op("and",    32'hF0F0_1234, 32'h0FF0_FFFF, S_AND, 1'b1, 1'b1, 32'h00F0_1234, 1'b0, 1'b0);

        // start held for 20 cycles with operands changing every cycle:
        // only the cycles 0, 6, 12, 18 are accepted.
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            a = 32'h0F0F_0F0F * 32'(i + 1);
            b = 32'h1111_1111 * 32'(19 - i) + 32'h00FF_FF01;
            s = S_ADD; m = 1'b0; c_in = 1'b1; start = 1'b1;
            if (i % 6 == 0) begin
                sum33 = {1'b0, a} + {1'b0, b};
                sb.push_back('{f: sum33[31:0], c: ~sum33[32], eq: (sum33[31:0] == 32'hFFFF_FFFF),
                               cyc_done: cyc + 5, name: $sformatf("b2b%0d", i)});
            end
            @(negedge clk);
        end
        start = 1'b0;
        wait_idle();

        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
